// File: rtl/sprite_blitter.sv
// CHIP-8 DXYN draw / 00E0 clear engine for a 64x32 monochrome frame buffer.
// Sprite rows are fetched over a req/ack port and XORed into VRAM over a shared tri-state bus.
module sprite_blitter #(
  parameter int VBITS = 14,
  parameter int VBASE = 0,
  parameter int WRAP  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cls,
  input  logic [7:0]       x,
  input  logic [7:0]       y,
  input  logic [3:0]       n,
  input  logic [11:0]      i_addr,
  output logic             busy,
  output logic             done,
  output logic             collision,
  output logic             mem_req,
  output logic [11:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [7:0]       mem_rdata,
  output logic [VBITS-1:0] vram_address,
  output logic             vram_select,
  output logic             vram_write,
  inout  wire  [7:0]       vram_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_RDL, S_WRL, S_RDR, S_WRR, S_NEXT, S_CLR, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  col_q, s_q;
  logic [4:0]  y0_q;
  logic [3:0]  n_q;
  logic [11:0] ia_q;
  logic [4:0]  r_q, r_d;
  logic [7:0]  spr_q, spr_d, old_q, old_d, clr_q, clr_d;
  logic        coll_q, coll_d;
  logic        accept, addr_en, right_ok;
  logic [4:0]  row;
  logic [2:0]  col_r;
  logic [7:0]  pat_l, pat_r, wdata, byte_idx;
  logic        unused_ok;

  assign unused_ok = ^{x[7:6], y[7:5]};

  // 5-bit sum wraps the row modulo 32; clipping is decided in NEXT before it matters
  assign row      = y0_q + r_q;
  assign col_r    = col_q + 3'd1;
  assign pat_l    = spr_q >> s_q;
  assign pat_r    = spr_q << (4'd8 - {1'b0, s_q});
  assign right_ok = (s_q != 3'd0) && ((col_q != 3'd7) || (WRAP != 0));

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    spr_d       = spr_q;
    old_d       = old_q;
    coll_d      = coll_q;
    clr_d       = clr_q;
    accept      = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    vram_select = 1'b0;
    vram_write  = 1'b0;
    addr_en     = 1'b0;
    byte_idx    = '0;
    wdata       = '0;
    case (state_q)
      S_IDLE: begin
        if (cls) begin
          accept  = 1'b1;
          clr_d   = '0;
          state_d = S_CLR;
        end else if (start) begin
          accept  = 1'b1;
          r_d     = '0;
          state_d = (n == 4'd0) ? S_DONE : S_FETCH;
        end
        if (accept) coll_d = 1'b0;
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = ia_q + 12'(r_q);
        if (mem_ack) begin
          spr_d   = mem_rdata;
          state_d = S_RDL;
        end
      end
      S_RDL: begin
        vram_select = 1'b1;
        addr_en     = 1'b1;
        byte_idx    = {row, col_q};
        old_d       = vram_data;
        state_d     = S_WRL;
      end
      S_WRL: begin
        vram_write = 1'b1;
        addr_en    = 1'b1;
        byte_idx   = {row, col_q};
        wdata      = old_q ^ pat_l;
        if ((old_q & pat_l) != 8'd0) coll_d = 1'b1;
        state_d    = right_ok ? S_RDR : S_NEXT;
      end
      S_RDR: begin
        vram_select = 1'b1;
        addr_en     = 1'b1;
        byte_idx    = {row, col_r};
        old_d       = vram_data;
        state_d     = S_WRR;
      end
      S_WRR: begin
        vram_write = 1'b1;
        addr_en    = 1'b1;
        byte_idx   = {row, col_r};
        wdata      = old_q ^ pat_r;
        if ((old_q & pat_r) != 8'd0) coll_d = 1'b1;
        state_d    = S_NEXT;
      end
      S_NEXT: begin
        r_d = r_q + 5'd1;
        if (r_d == {1'b0, n_q})
          state_d = S_DONE;
        else if (((6'(y0_q) + 6'(r_q) + 6'd1) >= 6'd32) && (WRAP == 0))
          state_d = S_DONE;
        else
          state_d = S_FETCH;
      end
      S_CLR: begin
        vram_write = 1'b1;
        addr_en    = 1'b1;
        byte_idx   = clr_q;
        clr_d      = clr_q + 8'd1;
        if (clr_q == 8'hFF) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    vram_address = addr_en ? (VBITS'(VBASE) + VBITS'(byte_idx)) : '0;
  end

  assign vram_data = vram_write ? wdata : 8'bz;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign collision = coll_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      s_q     <= '0;
      y0_q    <= '0;
      n_q     <= '0;
      ia_q    <= '0;
      r_q     <= '0;
      spr_q   <= '0;
      old_q   <= '0;
      clr_q   <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      spr_q   <= spr_d;
      old_q   <= old_d;
      clr_q   <= clr_d;
      coll_q  <= coll_d;
      if (accept) begin
        col_q <= x[5:3];
        s_q   <= x[2:0];
        y0_q  <= y[4:0];
        n_q   <= n;
        ia_q  <= i_addr;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: one instance clips (WRAP=0), one wraps (WRAP=1).
// A pixel-level frame-buffer model predicts image, VF, fetch count and done latency.
module tb_sprite_blitter;
  localparam int VB = 256;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cls = 1'b0;
  logic [7:0]  x = '0, y = '0;
  logic [3:0]  n = '0;
  logic [11:0] ia = '0;

  logic [1:0] busy, done, coll, mreq, mack, vsel, vwr;
  logic [1:0][11:0] maddr;
  logic [1:0][13:0] vaddr;
  logic [1:0][7:0]  mrdata, vdat, rdbyte;

  logic [7:0] rom [4096];
  logic [7:0] vr  [2][256];
  logic [7:0] mv  [2][256];

  int unsigned dly = 0, cyc = 0;
  int unsigned wcnt [2];
  int unsigned nacks [2];
  logic [1:0] preq, pack;
  logic [1:0][11:0] paddr;
  int unsigned n_cmp = 0, n_bad = 0;
  bit chk_off = 1'b0;

  typedef struct packed {
    logic [31:0]      tstart;
    logic [31:0]      cycles;
    logic             coll;
    logic [31:0]      rows;
    logic [11:0]      ia;
    logic [255:0][7:0] img;
  } exp_t;
  exp_t sb0[$], sb1[$];

  always #5 clk = ~clk;

  for (genvar G = 0; G < 2; G++) begin : g_dut
    wire [7:0] vd;
    assign vd      = (vsel[G] && !vwr[G]) ? rdbyte[G] : 8'bz;
    assign vdat[G] = vd;
    sprite_blitter #(.VBITS(14), .VBASE(VB), .WRAP(G)) u_dut (
      .clk(clk), .reset(rst_n), .start(start), .cls(cls),
      .x(x), .y(y), .n(n), .i_addr(ia),
      .busy(busy[G]), .done(done[G]), .collision(coll[G]),
      .mem_req(mreq[G]), .mem_addr(maddr[G]), .mem_ack(mack[G]), .mem_rdata(mrdata[G]),
      .vram_address(vaddr[G]), .vram_select(vsel[G]), .vram_write(vwr[G]),
      .vram_data(vd)
    );
  end

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      mack[g]   = mreq[g] && (wcnt[g] == dly);
      mrdata[g] = rom[maddr[g]];
      rdbyte[g] = vr[g][8'(vaddr[g] - 14'(VB))];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++) begin
      if (mreq[g] && !mack[g]) wcnt[g] <= wcnt[g] + 1;
      else wcnt[g] <= 0;
      if (vwr[g]) vr[g][8'(vaddr[g] - 14'(VB))] <= vdat[g];
    end
  end

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s[wrap=%0d] t=%0t: got %0h expected %0h", nm, g, $time, act, exp_v);
    end
  endtask

  function automatic int sb_size(input int g);
    return (g == 0) ? sb0.size() : sb1.size();
  endfunction

  // Monitor: bus protocol every cycle, fetch addresses on ack, full result on done
  always @(negedge clk) begin
    exp_t e;
    int unsigned diffs;
    if (!rst_n) begin
      preq  <= '0;
      pack  <= '0;
      nacks[0] <= 0;
      nacks[1] <= 0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (mreq[g] || vsel[g] || vwr[g]) begin
          chk("sel_wr_exclusive", g, 32'(vsel[g] && vwr[g]), 0);
          chk("vram_quiet_in_fetch", g, 32'(mreq[g] && (vsel[g] || vwr[g])), 0);
        end
        if (vsel[g] || vwr[g])
          chk("vram_addr_range", g, 32'((vaddr[g] >= 14'(VB)) && (vaddr[g] < 14'(VB + 256))), 1);
        if (preq[g] && !pack[g]) begin
          chk("req_held", g, 32'(mreq[g]), 1);
          chk("addr_held", g, 32'(maddr[g]), 32'(paddr[g]));
        end
        if (mack[g] && !chk_off) begin
          if (sb_size(g) == 0) chk("unexpected_fetch", g, 1, 0);
          else begin
            e = (g == 0) ? sb0[0] : sb1[0];
            chk("mem_addr", g, 32'(maddr[g]), 32'(12'(e.ia + nacks[g])));
          end
          nacks[g] <= nacks[g] + 1;
        end
        if (done[g] && !chk_off) begin
          if (sb_size(g) == 0) chk("unexpected_done", g, 1, 0);
          else begin
            if (g == 0) e = sb0.pop_front(); else e = sb1.pop_front();
            chk("done_cycle", g, cyc - e.tstart, e.cycles);
            chk("collision", g, 32'(coll[g]), 32'(e.coll));
            chk("busy_at_done", g, 32'(busy[g]), 0);
            chk("rows_fetched", g, nacks[g], e.rows);
            diffs = 0;
            for (int k = 0; k < 256; k++) if (vr[g][k] !== e.img[k]) diffs++;
            chk("vram_bytes_wrong", g, diffs, 0);
          end
          nacks[g] <= 0;
        end
        preq[g]  <= mreq[g];
        pack[g]  <= mack[g];
        paddr[g] <= maddr[g];
      end
    end
  end

  task automatic push(input int g, input exp_t e);
    if (g == 0) sb0.push_back(e); else sb1.push_back(e);
  endtask

  task automatic issue_draw(input logic [7:0] xx, input logic [7:0] yy, input logic [3:0] nn,
                            input logic [11:0] iaa, input int unsigned d);
    exp_t e;
    int unsigned x0, y0, yr, xp, rows;
    logic [7:0] b;
    bit c, wr, right;
    @(negedge clk);
    dly = d; x = xx; y = yy; n = nn; ia = iaa; start = 1'b1;
    for (int g = 0; g < 2; g++) begin
      wr = (g == 1); x0 = xx % 64; y0 = yy % 32; c = 1'b0; rows = 0;
      for (int j = 0; j < int'(nn); j++) begin
        yr = y0 + j;
        if (yr >= 32) begin
          if (!wr) break;
          yr = yr - 32;
        end
        rows++;
        b = rom[12'(iaa + 12'(j))];
        for (int k = 0; k < 8; k++) begin
          if (b[7-k]) begin
            xp = x0 + k;
            if (xp >= 64) begin
              if (!wr) continue;
              xp = xp - 64;
            end
            if (mv[g][yr*8 + xp/8][7 - xp%8]) c = 1'b1;
            mv[g][yr*8 + xp/8][7 - xp%8] = ~mv[g][yr*8 + xp/8][7 - xp%8];
          end
        end
      end
      right = (x0 % 8 != 0) && ((x0 / 8 != 7) || wr);
      e.tstart = cyc;
      e.cycles = 1 + rows * (d + 4) + (right ? 2 * rows : 0);
      e.coll   = c;
      e.rows   = rows;
      e.ia     = iaa;
      for (int k = 0; k < 256; k++) e.img[k] = mv[g][k];
      push(g, e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_cls(input bit also_start);
    exp_t e;
    @(negedge clk);
    cls = 1'b1; start = also_start; x = 8'd5; n = 4'd3;
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 256; k++) mv[g][k] = 8'h00;
      e.tstart = cyc; e.cycles = 257; e.coll = 1'b0; e.rows = 0; e.ia = '0;
      for (int k = 0; k < 256; k++) e.img[k] = 8'h00;
      push(g, e);
    end
    @(negedge clk);
    cls = 1'b0; start = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (((busy != 0) || (done != 0) || (sb0.size() != 0) || (sb1.size() != 0)) && t < 3000);
    if (t >= 3000) chk("timeout_waiting_done", 0, 1, 0);
    @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk({tag, "_busy"}, g, 32'(busy[g]), 0);
      chk({tag, "_done"}, g, 32'(done[g]), 0);
      chk({tag, "_collision"}, g, 32'(coll[g]), 0);
      chk({tag, "_mem_req"}, g, 32'(mreq[g]), 0);
      chk({tag, "_mem_addr"}, g, 32'(maddr[g]), 0);
      chk({tag, "_vram_select"}, g, 32'(vsel[g]), 0);
      chk({tag, "_vram_write"}, g, 32'(vwr[g]), 0);
      chk({tag, "_vram_address"}, g, 32'(vaddr[g]), 0);
    end
  endtask

  initial begin
    int unsigned t;
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    for (int g = 0; g < 2; g++) for (int k = 0; k < 256; k++) mv[g][k] = 8'h00;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    issue_cls(1'b0); wait_idle();
    rom[12'h200] = 8'hF0;
    issue_draw(8'd0, 8'd0, 4'd1, 12'h200, 0); wait_idle();
    issue_draw(8'd0, 8'd0, 4'd1, 12'h200, 0); wait_idle();
    issue_cls(1'b0); wait_idle();
    rom[12'h201] = 8'hFF;
    issue_draw(8'd4, 8'd0, 4'd1, 12'h201, 0); wait_idle();
    issue_cls(1'b0); wait_idle();
    issue_draw(8'd60, 8'd0, 4'd1, 12'h201, 0); wait_idle();
    issue_cls(1'b0); wait_idle();
    issue_draw(8'd70, 8'd30, 4'd4, 12'h300, 1); wait_idle();
    issue_draw(8'd9, 8'd5, 4'd3, 12'h210, 3); wait_idle();

    // commands arriving while busy must be dropped
    issue_draw(8'd12, 8'd7, 4'd5, 12'h220, 2);
    @(negedge clk); start = 1'b1; x = 8'd33; n = 4'd2;
    @(negedge clk); start = 1'b0; cls = 1'b1;
    @(negedge clk); cls = 1'b0;
    wait_idle();

    issue_cls(1'b1); wait_idle();
    issue_draw(8'd5, 8'd5, 4'd0, 12'h100, 0); wait_idle();
    issue_draw(8'd17, 8'd3, 4'd4, 12'hFFE, 1); wait_idle();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) issue_cls(1'(($urandom_range(0, 1))));
      else issue_draw(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)),
                      12'($urandom), $urandom_range(0, 3));
      wait_idle();
    end

    // asynchronous reset in the middle of a left-byte write
    chk_off = 1'b1;
    @(negedge clk);
    dly = 0; x = 8'd3; y = 8'd1; n = 4'd2; ia = 12'h240; start = 1'b1;
    @(negedge clk); start = 1'b0;
    t = 0;
    while (!vwr[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("reached_write_before_reset", 0, 32'(vwr[0]), 1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_outputs_zero("idle_after_reset");
    chk_off = 1'b0;
    issue_cls(1'b0); wait_idle();
    issue_draw(8'd2, 8'd31, 4'd2, 12'h250, 0); wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Executes the CHIP-8 DXYN draw and 00E0 clear operations against the 64×32 monochrome frame buffer held in `Vram`. It sits directly upstream of `Vram`, fetches sprite rows from main memory over a request/acknowledge port, and performs read-XOR-write on the shared tri-state VRAM bus. It reports pixel collision for VF.

## Interface

Parameters:
- `VBITS`, 14: VRAM address width. Matches the `Vram` `BITS` parameter.
- `VBASE`, 0: VRAM byte address of frame-buffer byte 0.
- `WRAP`, 0: edge handling. 0 clips pixels past the right or bottom edge. 1 wraps them.

Ports:
- `clk`  in  1: the single clock. All state changes on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle draw request.
- `cls`  in  1: one-cycle clear request.
- `x`  in  8: sprite X coordinate (VX).
- `y`  in  8: sprite Y coordinate (VY).
- `n`  in  4: sprite height in rows.
- `i_addr`  in  12: address of the first sprite row (I).
- `busy`  out  1: high from the cycle after acceptance until `done`.
- `done`  out  1: one-cycle completion pulse.
- `collision`  out  1: VF result. Valid from `done` until the next acceptance.
- `mem_req`  out  1: sprite-byte read request.
- `mem_addr`  out  12: sprite-byte address.
- `mem_ack`  in  1: read acknowledge. `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  8: sprite byte.
- `vram_address`  out  VBITS: VRAM address.
- `vram_select`  out  1: VRAM read enable. Data is combinational in the same cycle.
- `vram_write`  out  1: VRAM write enable. Committed on the rising edge.
- `vram_data`  inout  8: tri-state bus. Driven only while `vram_write` is high, otherwise high-Z.

## Operation

Frame-buffer layout:
- 8 bytes per row, 256 bytes in total.
- Byte address = `VBASE + row*8 + col/8`.
- Bit 7 is the leftmost pixel.

Command acceptance:
- `start` and `cls` are sampled only in IDLE. Both are ignored while busy.
- `cls` has priority when both are asserted in the same cycle.
- On acceptance the block latches:
  - `x0 = x mod 64` and `y0 = y mod 32`;
  - `n` and `i_addr`;
  - `s = x0 mod 8`;
  - `collision` is cleared to 0.

State machine:
- **IDLE**: on `cls` go to CLR. On `start` with n≠0 go to FETCH. On `start` with n=0 go to DONE.
- **FETCH**:
  - Hold `mem_req=1` with `mem_addr = i_addr + r`, where r is the current row.
  - `i_addr + r` is computed in 12 bits and wraps.
  - On `mem_ack`, latch `mem_rdata` and go to RDL.
- **RDL**: select byte (row, col0 = x0/8) with `vram_select=1`. Capture `old`.
- **WRL**:
  - Write `old ^ (spr >> s)`.
  - Set `collision` if `old & (spr >> s)` is nonzero.
  - If s≠0 and the right byte exists, go to RDR. Otherwise go to NEXT.
- **RDR, WRR**: same as RDL/WRL on column col0+1, using pattern `(spr << (8-s))` truncated to 8 bits.
  - If col0+1 = 8 and WRAP=1, use column 0.
  - If col0+1 = 8 and WRAP=0, the right byte does not exist. Skip RDR/WRR.
- **NEXT**: r++. Go to DONE if r = n. Otherwise handle the next row (y0+r):
  - If y0+r ≥ 32 and WRAP=0, go to DONE.
  - If y0+r ≥ 32 and WRAP=1, use row (y0+r) mod 32 and go to FETCH.
  - Otherwise go to FETCH.
- **CLR**: write 0x00 to bytes 0..255, one byte per cycle, then go to DONE.
- **DONE**: pulse `done` for one cycle, then go to IDLE.

Bus rules:
- `vram_select` and `vram_write` are never high in the same cycle.
- `mem_addr` stays stable while `mem_req` is high and not yet acknowledged.

Reset:
- Takes effect immediately: state goes to IDLE.
- All outputs go to 0: `busy`, `done`, `collision`, `mem_req`, `vram_select`, `vram_write`, `vram_address`, `mem_addr`.
- `vram_data` goes high-Z.
- A partially drawn sprite remains in VRAM. This is accepted.

## Timing

- Acceptance edge = cycle 0. `busy` is high from cycle 1.
- Each row takes:
  - (FETCH wait + 1) + 2 cycles when aligned or when the right byte is clipped;
  - 2 more cycles when unaligned and the right byte exists;
  - plus 1 cycle in NEXT.
- With zero-wait `mem_ack`, an aligned n-row draw asserts `done` at cycle 4n+1.
- n=0: `done` at cycle 1, `collision` = 0.
- Clear: writes occur in cycles 1..256 and `done` is at cycle 257.
- `busy` falls in the same cycle `done` rises.
- A new command can be accepted in the cycle after `done`.

## Test plan

- Blank VRAM; draw x=0, y=0, n=1, row byte 0xF0:
  - → byte 0 = 0xF0, `collision`=0, `done` at cycle 5.
  - Repeat the same draw → byte 0 = 0x00, `collision`=1.
- Draw x=4, y=0, row 0xFF → byte 0 = 0x0F, byte 1 = 0xF0, `collision`=0.
- Draw x=60, row 0xFF:
  - WRAP=0 → byte 7 = 0x0F, byte 0 untouched.
  - WRAP=1 → byte 0 = 0xF0 as well.
- Draw x=70, y=30, n=4 with WRAP=0 → drawn at column 6. Only rows 30 and 31 are written. `mem_addr` never reaches `i_addr`+2. `done` is asserted.
- `mem_ack` delayed 3 cycles → `mem_req`/`mem_addr` held stable, no VRAM activity during the wait.
- Other control scenarios:
  - `cls` → all 256 bytes are 0x00 and `done` at cycle 257.
  - `start` while busy → ignored.
  - `reset` low during WRL → outputs 0, bus high-Z, block in IDLE.
